fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the decode/control stage.
//  - Owns the PC and issues in-order requests to instruction memory.
//  - Buffers returned instructions with their PCs and presents them to decode over a valid/ready interface.
//  - On a branch/jump redirect from EX, discards all buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers responses with PCs for decode.
// Latency: response in cycle N is visible on id_* in cycle N+1 at the earliest (all id_* come from slot state).
// Backpressure: id_ready low holds the head; once all DEPTH slots are allocated, no new request is issued.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   input  logic            id_ready
);

   localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW  = PW + 1;
   // Drop counter is wider than one ring's worth so that several redirects
   // in a row with a slow memory cannot wrap it.
   localparam int          DW  = CW + 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Fetch PC and the slot ring (pc/instr payload plus a filled flag per slot).
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  slot_pc    [DEPTH];
   logic [31:0]      slot_instr [DEPTH];
   logic [DEPTH-1:0] slot_filled;

   // wr_ptr: next slot to allocate; rsp_ptr: next slot a response fills;
   // rd_ptr: head slot presented to decode.
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rsp_ptr;
   logic [PW-1:0]    rd_ptr;

   // occ: allocated slots; pend: allocated but still waiting for data;
   // drop_cnt: responses still owed by memory for fetches a redirect killed.
   logic [CW-1:0]    occ;
   logic [CW-1:0]    pend;
   logic [DW-1:0]    drop_cnt;

   logic             req_fire;
   logic             rsp_drop;
   logic             rsp_take;
   logic             pop;
   logic [XLEN-1:0]  redirect_target;
   logic [1:0]       redirect_pc_unused;

   // The target is always fetched word aligned; the low bits are ignored.
   assign redirect_target    = {redirect_pc[XLEN-1:2], 2'b00};
   assign redirect_pc_unused = redirect_pc[1:0];

   // Request only from registered occupancy: a slot freed by a pop this
   // cycle becomes requestable next cycle, keeping ready off the pop path.
   assign imem_req_valid = !rst && !redirect_valid && (occ < CW'(DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses for killed fetches drain first. A live response arriving in
   // a redirect cycle belongs to the old stream and is thrown away as well.
   assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_take = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

   // Decode sees only the head slot's registered contents.
   assign id_valid = slot_filled[rd_ptr];
   assign id_instr = id_valid ? slot_instr[rd_ptr] : NOP;
   assign id_pc    = id_valid ? slot_pc[rd_ptr]    : '0;
   assign pop      = id_valid && id_ready;

   // Control state: PC, pointers, counters and filled flags; a redirect
   // flushes the ring but whatever decode took in the same cycle stays taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         wr_ptr      <= '0;
         rsp_ptr     <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         pend        <= '0;
         drop_cnt    <= '0;
         slot_filled <= '0;
      end else if (redirect_valid) begin
         pc          <= redirect_target;
         wr_ptr      <= '0;
         rsp_ptr     <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         pend        <= '0;
         slot_filled <= '0;
         // Every unfilled slot still has a response coming; one arriving
         // right now (dropped or live) is consumed this cycle.
         drop_cnt    <= drop_cnt + DW'(pend) - DW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            pc     <= pc + XLEN'(4);
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rsp_take) begin
            rsp_ptr <= rsp_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         occ      <= occ + CW'(req_fire) - CW'(pop);
         pend     <= pend + CW'(req_fire) - CW'(rsp_take);
         drop_cnt <= drop_cnt - DW'(rsp_drop);
         // The slot being filled is never the head being popped: a poppable
         // head is already filled, the fill target never is.
         for (int i = 0; i < DEPTH; i++) begin
            if (rsp_take && (rsp_ptr == PW'(i))) begin
               slot_filled[i] <= 1'b1;
            end else if (pop && (rd_ptr == PW'(i))) begin
               slot_filled[i] <= 1'b0;
            end
         end
      end
   end

   // Slot payload: PC captured at allocation, instruction at fill. Contents
   // are only ever read while the filled flag is set, so no reset is needed.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         slot_pc[wr_ptr] <= pc;
      end
      if (rsp_take) begin
         slot_instr[rsp_ptr] <= imem_rsp_data;
      end
   end

   // A request the memory did not take must be presented unchanged.
   assert property (@(posedge clk) disable iff (rst)
      (imem_req_valid && !imem_req_ready) |=> (imem_req_addr == $past(imem_req_addr)));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: in-order memory model plus a stream-level reference model.
// Latency: memory answers each accepted request 1..N cycles later, in order.
// Backpressure: decode and memory ready are driven per scenario or randomly.
module tb_fetch_unit;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = '0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready       = 1'b0;

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
   );

   always #5 clk = ~clk;

   // Memory model: each accepted request tagged with the fetch stream (epoch) it belongs to.
   typedef struct {
      int          due;
      logic [31:0] addr;
      int          epoch;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] pcq[$];       // PCs fetched in the current stream, not yet consumed by decode
   int          m_filled;     // how many of those (from the front) have data back
   int          m_epoch;
   logic [31:0] m_req_pc;
   int          last_due;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [31:0] pop_log[$];
   int          pop_cyc[$];
   logic [31:0] req_log[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
   endfunction

   // One clock cycle: drive inputs, check outputs at negedge, advance the model.
   task automatic step(input bit rid, input bit rrq, input bit rv, input logic [31:0] tgt);
      bit          rsp_now;
      bit          exp_req_v;
      bit          exp_id_v;
      bit          req_fire;
      bit          pop;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      mreq_t       r;
      int          d;
      id_ready       = rid;
      imem_req_ready = rrq;
      redirect_valid = rv;
      redirect_pc    = tgt;
      rsp_now = (mq.size() > 0) && (mq[0].due == cyc);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : $urandom;
      @(negedge clk);
      exp_req_v = !rv && (pcq.size() < DEPTH);
      exp_id_v  = (m_filled > 0);
      exp_pc    = exp_id_v ? pcq[0] : 32'h0;
      exp_instr = exp_id_v ? mem_word(pcq[0]) : NOP;
      n_cmp++;
      if (imem_req_valid !== exp_req_v) begin
         n_bad++;
         $display("FAIL req_valid cyc=%0d: got %0b want %0b", cyc, imem_req_valid, exp_req_v);
      end
      n_cmp++;
      if (imem_req_addr !== m_req_pc) begin
         n_bad++;
         $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, imem_req_addr, m_req_pc);
      end
      n_cmp++;
      if (id_valid !== exp_id_v) begin
         n_bad++;
         $display("FAIL id_valid cyc=%0d: got %0b want %0b", cyc, id_valid, exp_id_v);
      end
      n_cmp++;
      if (id_pc !== exp_pc) begin
         n_bad++;
         $display("FAIL id_pc cyc=%0d: got %h want %h", cyc, id_pc, exp_pc);
      end
      n_cmp++;
      if (id_instr !== exp_instr) begin
         n_bad++;
         $display("FAIL id_instr cyc=%0d: got %h want %h", cyc, id_instr, exp_instr);
      end
      req_fire = (imem_req_valid === 1'b1) && rrq;
      pop      = (id_valid === 1'b1) && rid;
      // Decode consumption first (also honoured in a redirect cycle).
      if (pop) begin
         pop_log.push_back(id_pc);
         pop_cyc.push_back(cyc);
         if (pcq.size() > 0) void'(pcq.pop_front());
         if (m_filled > 0) m_filled--;
      end
      // Memory answers; only answers for the live stream count, never in a redirect cycle.
      if (rsp_now) begin
         r = mq.pop_front();
         if (r.epoch == m_epoch && !rv) m_filled++;
      end
      if (req_fire) begin
         req_log.push_back(imem_req_addr);
         d = cyc + $urandom_range(lat_max, lat_min);
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         mq.push_back('{due: d, addr: imem_req_addr, epoch: m_epoch});
         pcq.push_back(m_req_pc);
         m_req_pc = m_req_pc + 32'd4;
      end
      if (rv) begin
         pcq.delete();
         m_filled = 0;
         m_epoch++;
         m_req_pc = {tgt[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      id_ready       = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      mq.delete();
      pcq.delete();
      pop_log.delete();
      pop_cyc.delete();
      req_log.delete();
      m_filled = 0;
      m_epoch  = 0;
      m_req_pc = RESET_PC;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      last_due = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset id_valid: got %0b want 0", id_valid); end
      n_cmp++;
      if (id_instr !== NOP) begin n_bad++; $display("FAIL reset id_instr: got %h want %h", id_instr, NOP); end
      n_cmp++;
      if (id_pc !== 32'h0) begin n_bad++; $display("FAIL reset id_pc: got %h want 0", id_pc); end
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset req_valid: got %0b want 0", imem_req_valid); end
      do_reset();
   endtask

   task automatic test_stream();
      int start;
      do_reset();
      lat_min = 1; lat_max = 1;
      start = cyc;
      repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (pop_log.size() <= i || pop_log[i] !== 32'(4 * i)) begin
            n_bad++;
            $display("FAIL stream pc[%0d]: got %h want %h", i, (pop_log.size() > i) ? pop_log[i] : 32'hx, 32'(4 * i));
         end
         n_cmp++;
         if (pop_cyc.size() <= i || pop_cyc[i] != start + 2 + i) begin
            n_bad++;
            $display("FAIL stream pop_cycle[%0d]: got %0d want %0d", i, (pop_cyc.size() > i) ? pop_cyc[i] - start : -1, 2 + i);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (req_log.size() != DEPTH) begin n_bad++; $display("FAIL stall req_count: got %0d want %0d", req_log.size(), DEPTH); end
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall req_valid: got %0b want 0", imem_req_valid); end
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_bad++; $display("FAIL stall head: got %0b/%h want 1/0", id_valid, id_pc); end
      repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (pop_log.size() <= i || pop_log[i] !== 32'(4 * i)) begin
            n_bad++;
            $display("FAIL stall drain[%0d]: got %h want %h", i, (pop_log.size() > i) ? pop_log[i] : 32'hx, 32'(4 * i));
         end
      end
   endtask

   task automatic test_req_stall();
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (imem_req_addr !== 32'h10 || imem_req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL hold addr[%0d]: got %0b/%h want 1/00000010", i, imem_req_valid, imem_req_addr);
         end
         step(1'b1, 1'b0, 1'b0, 32'h0);
      end
      repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (req_log.size() < 6 || req_log[4] !== 32'h10 || req_log[5] !== 32'h14) begin
         n_bad++;
         $display("FAIL hold resume: got %h,%h want 00000010,00000014",
                  (req_log.size() > 4) ? req_log[4] : 32'hx, (req_log.size() > 5) ? req_log[5] : 32'hx);
      end
   endtask

   task automatic test_redirect();
      int bad_seen;
      do_reset();
      lat_min = 3; lat_max = 3;
      repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h103);
      repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
         n_bad++;
         $display("FAIL redirect first_pc: got %h want 00000100", (pop_log.size() > 0) ? pop_log[0] : 32'hx);
      end
      bad_seen = 0;
      foreach (pop_log[i]) if (pop_log[i] < 32'h100) bad_seen++;
      n_cmp++;
      if (bad_seen != 0) begin n_bad++; $display("FAIL redirect stale_pops: got %0d want 0", bad_seen); end
      n_cmp++;
      if (req_log.size() < 3 || req_log[2] !== 32'h100) begin
         n_bad++;
         $display("FAIL redirect req_addr: got %h want 00000100", (req_log.size() > 2) ? req_log[2] : 32'hx);
      end
   endtask

   task automatic test_coincident();
      int zeros;
      do_reset();
      lat_min = 3; lat_max = 3;
      repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL coincide setup: got v=%0b pc=%h req=%0b want 1/0/0", id_valid, id_pc, imem_req_valid);
      end
      step(1'b1, 1'b1, 1'b1, 32'h200);
      repeat (14) step(1'b1, 1'b1, 1'b0, 32'h0);
      zeros = 0;
      foreach (pop_log[i]) if (pop_log[i] == 32'h0) zeros++;
      n_cmp++;
      if (zeros != 1) begin n_bad++; $display("FAIL coincide pop_once: got %0d want 1", zeros); end
      n_cmp++;
      if (pop_log.size() < 2 || pop_log[1] !== 32'h200) begin
         n_bad++;
         $display("FAIL coincide next_pc: got %h want 00000200", (pop_log.size() > 1) ? pop_log[1] : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      lat_min = 1; lat_max = 3;
      repeat (9) step(1'b1, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0) begin
         n_bad++;
         $display("FAIL midreset id: got %0b/%h/%h want 0/%h/0", id_valid, id_instr, id_pc, NOP);
      end
      n_cmp++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
         n_bad++;
         $display("FAIL midreset req: got %0b/%h want 0/%h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      do_reset();
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (req_log.size() == 0 || req_log[0] !== RESET_PC) begin
         n_bad++;
         $display("FAIL midreset restart: got %h want %h", (req_log.size() > 0) ? req_log[0] : 32'hx, RESET_PC);
      end
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0, $urandom);
      end
      n_cmp++;
      if (pop_log.size() < 300) begin n_bad++; $display("FAIL random progress: got %0d pops want >=300", pop_log.size()); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_req_stall();
      test_redirect();
      test_coincident();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
